// File: rtl/digit_entry_loader_pkg.sv
// Shared game constants: digit geometry, BCD limit and entry FSM encoding.
package digit_entry_loader_pkg;

    localparam int DEF_DIGIT_W    = 4;
    localparam int DEF_NUM_DIGITS = 4;
    localparam int BCD_MAX        = 9;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } entry_state_t;

endpackage

// File: rtl/digit_entry_loader_slot_reg.sv
// One digit slot: load-enabled register with synchronous clear.
module digit_slot_reg #(
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    logic [DIGIT_W-1:0] val_q;
    logic [DIGIT_W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (ld) begin
            val_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/digit_entry_loader.sv
// Captures switch digits into slots on button pulses, tracks sum and fullness.
// Build option: DIGIT_ENTRY_BCD_CHECK_EN rejects digits above 9.
module digit_entry_loader
    import digit_entry_loader_pkg::*;
#(
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int CNT_W      = 3,
    parameter int SUM_W      = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          button_pulse,
    input  logic [DIGIT_W-1:0]            sw_in,
    input  logic                          clear,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits_out,
    output logic [SUM_W-1:0]              sum_out,
    output logic [CNT_W-1:0]              entry_count,
    output logic                          load_strobe,
    output logic                          set_full,
    output logic                          digit_err
);

    entry_state_t    state_q;
    entry_state_t    state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic             strobe_q;
    logic             strobe_d;
    logic             full_q;
    logic             full_d;
    logic             err_q;
    logic             err_d;

    logic             can_cap;
    logic             bad_digit;
    logic             accept;
    logic [CNT_W-1:0] base_cnt;
    logic [SUM_W-1:0] base_sum;
    logic [CNT_W-1:0] next_cnt;

`ifdef DIGIT_ENTRY_BCD_CHECK_EN
    assign bad_digit = (sw_in > DIGIT_W'(BCD_MAX));
`else
    assign bad_digit = 1'b0;
`endif

    // Illegal state encodings behave exactly like EMPTY.
    always_comb begin
        can_cap  = 1'b0;
        base_cnt = '0;
        base_sum = '0;
        case (state_q)
            ST_COLLECT: begin
                can_cap  = 1'b1;
                base_cnt = count_q;
                base_sum = sum_q;
            end
            ST_FULL: begin
                can_cap  = 1'b0;
                base_cnt = count_q;
                base_sum = sum_q;
            end
            default: begin
                can_cap  = 1'b1;
            end
        endcase
    end

    assign accept   = button_pulse && !clear && can_cap && !bad_digit;
    assign next_cnt = base_cnt + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sum_d    = sum_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        if (clear) begin
            state_d = ST_EMPTY;
            count_d = '0;
            sum_d   = '0;
        end else if (accept) begin
            count_d  = next_cnt;
            sum_d    = base_sum + SUM_W'(sw_in);
            strobe_d = 1'b1;
            if (next_cnt == CNT_W'(NUM_DIGITS)) begin
                state_d = ST_FULL;
            end else begin
                state_d = ST_COLLECT;
            end
        end else if (button_pulse && can_cap) begin
            err_d = 1'b1;
        end
        full_d = (state_d == ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_EMPTY;
            count_q  <= '0;
            sum_q    <= '0;
            strobe_q <= 1'b0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            strobe_q <= strobe_d;
            full_q   <= full_d;
            err_q    <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_slot
        logic ld;
        assign ld = accept && (base_cnt == CNT_W'(i));
        digit_slot_reg #(
            .DIGIT_W(DIGIT_W)
        ) u_slot (
            .clk(clk),
            .rst(rst),
            .clr(clear),
            .ld (ld),
            .d  (sw_in),
            .q  (digits_out[i*DIGIT_W +: DIGIT_W])
        );
    end

    assign sum_out     = sum_q;
    assign entry_count = count_q;
    assign load_strobe = strobe_q;
    assign set_full    = full_q;
    assign digit_err   = err_q;

endmodule

// File: tb/tb_digit_entry_loader.sv
// Directed self-checking bench for digit_entry_loader at default parameters.
module tb_digit_entry_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        button_pulse = 1'b0;
    logic [3:0]  sw_in = '0;
    logic        clear = 1'b0;
    logic [15:0] digits_out;
    logic [5:0]  sum_out;
    logic [2:0]  entry_count;
    logic        load_strobe;
    logic        set_full;
    logic        digit_err;

    int total = 0;
    int passed = 0;
    int strobes = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (load_strobe === 1'b1) strobes++;

    digit_entry_loader dut (
        .clk(clk),
        .rst(rst),
        .button_pulse(button_pulse),
        .sw_in(sw_in),
        .clear(clear),
        .digits_out(digits_out),
        .sum_out(sum_out),
        .entry_count(entry_count),
        .load_strobe(load_strobe),
        .set_full(set_full),
        .digit_err(digit_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        button_pulse = 1'b1;
        sw_in = v;
        tick();
        button_pulse = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            button_pulse = i[0];
            sw_in = 4'd5;
            tick();
            total++;
            if ({digits_out, sum_out, entry_count, load_strobe,
                 set_full, digit_err} !== '0)
                $display("FAIL reset_hold cyc%0d: got d=%h s=%0d c=%0d st=%b f=%b e=%b want all 0",
                         i, digits_out, sum_out, entry_count,
                         load_strobe, set_full, digit_err);
            else passed++;
        end
        button_pulse = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if (entry_count !== 3'd0 || set_full !== 1'b0 || load_strobe !== 1'b0)
            $display("FAIL reset_release: got c=%0d f=%b st=%b want 0 0 0",
                     entry_count, set_full, load_strobe);
        else passed++;
    endtask

    task automatic test_full_entry();
        logic [3:0] vals [4] = '{4'd3, 4'd7, 4'd2, 4'd8};
        int s0;
        s0 = strobes;
        for (int i = 0; i < 4; i++) begin
            pulse(vals[i]);
            total++;
            if (load_strobe !== 1'b1 || entry_count !== 3'(i + 1) ||
                set_full !== (i == 3))
                $display("FAIL full_step%0d: got st=%b c=%0d f=%b want 1 %0d %0d",
                         i, load_strobe, entry_count, set_full, i + 1, i == 3);
            else passed++;
            tick();
            total++;
            if (load_strobe !== 1'b0)
                $display("FAIL full_gap%0d: got st=%b want 0", i, load_strobe);
            else passed++;
        end
        total++;
        if (digits_out !== 16'h8273 || sum_out !== 6'd20 || entry_count !== 3'd4)
            $display("FAIL full_result: got d=%h s=%0d c=%0d want 8273 20 4",
                     digits_out, sum_out, entry_count);
        else passed++;
        total++;
        if (strobes - s0 !== 4)
            $display("FAIL full_strobes: got %0d want 4", strobes - s0);
        else passed++;
    endtask

    task automatic test_overflow_ignore();
        pulse(4'd5);
        total++;
        if (load_strobe !== 1'b0 || digits_out !== 16'h8273 || sum_out !== 6'd20 ||
            entry_count !== 3'd4 || set_full !== 1'b1 || digit_err !== 1'b0)
            $display("FAIL overflow: got st=%b d=%h s=%0d c=%0d f=%b e=%b want 0 8273 20 4 1 0",
                     load_strobe, digits_out, sum_out, entry_count, set_full, digit_err);
        else passed++;
    endtask

    task automatic test_clear_collision();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (entry_count !== 3'd0 || set_full !== 1'b0 || digits_out !== 16'h0)
            $display("FAIL clear_full: got c=%0d f=%b d=%h want 0 0 0000",
                     entry_count, set_full, digits_out);
        else passed++;
        pulse(4'd6);
        pulse(4'd4);
        total++;
        if (sum_out !== 6'd10 || entry_count !== 3'd2 || digits_out !== 16'h0046)
            $display("FAIL pre_collide: got s=%0d c=%0d d=%h want 10 2 0046",
                     sum_out, entry_count, digits_out);
        else passed++;
        clear = 1'b1;
        pulse(4'd9);
        clear = 1'b0;
        total++;
        if (entry_count !== 3'd0 || sum_out !== 6'd0 ||
            digits_out !== 16'h0 || load_strobe !== 1'b0)
            $display("FAIL collide: got c=%0d s=%0d d=%h st=%b want 0 0 0000 0",
                     entry_count, sum_out, digits_out, load_strobe);
        else passed++;
        pulse(4'd4);
        total++;
        if (digits_out !== 16'h0004 || sum_out !== 6'd4 || entry_count !== 3'd1)
            $display("FAIL post_collide: got d=%h s=%0d c=%0d want 0004 4 1",
                     digits_out, sum_out, entry_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        pulse(4'd1);
        pulse(4'd2);
        total++;
        if (entry_count !== 3'd3 || sum_out !== 6'd7 || digits_out !== 16'h0214)
            $display("FAIL mid_pre: got c=%0d s=%0d d=%h want 3 7 0214",
                     entry_count, sum_out, digits_out);
        else passed++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++;
        if ({digits_out, sum_out, entry_count, load_strobe,
             set_full, digit_err} !== '0)
            $display("FAIL mid_reset: got d=%h s=%0d c=%0d want all 0",
                     digits_out, sum_out, entry_count);
        else passed++;
    endtask

    task automatic test_back_to_back();
        button_pulse = 1'b1;
        sw_in = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (load_strobe !== 1'b1 || entry_count !== 3'(i + 1))
                $display("FAIL b2b%0d: got st=%b c=%0d want 1 %0d",
                         i, load_strobe, entry_count, i + 1);
            else passed++;
        end
        tick();
        button_pulse = 1'b0;
        total++;
        if (sum_out !== 6'd60 || set_full !== 1'b1 ||
            digits_out !== 16'hFFFF || load_strobe !== 1'b0)
            $display("FAIL b2b_result: got s=%0d f=%b d=%h st=%b want 60 1 ffff 0",
                     sum_out, set_full, digits_out, load_strobe);
        else passed++;
    endtask

    task automatic test_bcd();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        pulse(4'd12);
`ifdef DIGIT_ENTRY_BCD_CHECK_EN
        total++;
        if (digit_err !== 1'b1 || entry_count !== 3'd0 ||
            load_strobe !== 1'b0 || sum_out !== 6'd0)
            $display("FAIL bcd_reject: got e=%b c=%0d st=%b s=%0d want 1 0 0 0",
                     digit_err, entry_count, load_strobe, sum_out);
        else passed++;
        tick();
        total++;
        if (digit_err !== 1'b0)
            $display("FAIL bcd_err_len: got e=%b want 0", digit_err);
        else passed++;
`else
        total++;
        if (digit_err !== 1'b0 || entry_count !== 3'd1 ||
            sum_out !== 6'd12 || digits_out !== 16'h000C || load_strobe !== 1'b1)
            $display("FAIL bcd_accept: got e=%b c=%0d s=%0d d=%h st=%b want 0 1 12 000c 1",
                     digit_err, entry_count, sum_out, digits_out, load_strobe);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_full_entry();
        test_overflow_ignore();
        test_clear_collision();
        test_reset_mid();
        test_back_to_back();
        test_bcd();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
